// File: rtl/spine_pkg.sv
// Shared definitions for the spine output-port buffer: default sizes,
// the destination-field location inside a packet and the buffer FSM states.
package spine_pkg;

    // Default packet width and output-buffer depth.
    localparam int DWIDTH_DEFAULT     = 16;
    localparam int OBUF_DEPTH_DEFAULT = 4;

    // Destination field occupies packet bits 15:10.
    localparam int DEST_MSB   = 15;
    localparam int DEST_LSB   = 10;
    localparam int DEST_WIDTH = DEST_MSB - DEST_LSB + 1;

    // Occupancy states of the output buffer.
    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2
    } obuf_state_t;

endpackage

// File: rtl/spine_sync_fifo.sv
// Circular storage with first-word fall-through read for the spine
// output-port buffer. The caller qualifies push/pop; this block only
// moves pointers and the occupancy count. Storage itself is never reset.
module spine_sync_fifo
    import spine_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEFAULT,
    parameter int DEPTH  = OBUF_DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DWIDTH-1:0]        wr_data,
    output logic [DWIDTH-1:0]        rd_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DWIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;

    // Pointer and count update; DEPTH is a power of two so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // Pointer/count registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

endmodule

// File: rtl/spine_out_port_buffer.sv
// Output-port buffer between a spine router port and its link.
// Adds occupancy FSM, flush, sticky overflow flag and optional statistics
// around spine_sync_fifo. Define SPINE_OBUF_STATS_EN to get the
// pkt_fwd_cnt / pkt_drop_cnt saturating counters.
module spine_out_port_buffer
    import spine_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEFAULT,
    parameter int DEPTH  = OBUF_DEPTH_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic              wr_valid,
    output logic              fifo_full,
    input  logic              flush,
    output logic [DWIDTH-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overflow_err
`ifdef SPINE_OBUF_STATS_EN
    ,
    output logic [15:0]       pkt_fwd_cnt,
    output logic [15:0]       pkt_drop_cnt
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    obuf_state_t   state_q, state_d;
    logic          overflow_q, overflow_d;
    logic [CW-1:0] fifo_count;
    logic          push_acc;
    logic          pop_acc;
    logic          push_drop;

    // Full and valid come straight from the registered FSM state.
    assign fifo_full = (state_q == ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);

    // Flush overrides any concurrent push or pop; a push into a full buffer is dropped.
    assign push_acc  = wr_valid && !fifo_full && !flush;
    assign pop_acc   = out_valid && out_ready && !flush;
    assign push_drop = wr_valid && fifo_full && !flush;

    spine_sync_fifo #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush),
        .push    (push_acc),
        .pop     (pop_acc),
        .wr_data (wr_data),
        .rd_data (out_data),
        .count   (fifo_count)
    );

    // Occupancy next-state from net push/pop; flush returns to EMPTY.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (push_acc) begin
                        state_d = ST_PARTIAL;
                    end
                end
                ST_PARTIAL: begin
                    if (push_acc && !pop_acc && (fifo_count == CW'(DEPTH - 1))) begin
                        state_d = ST_FULL;
                    end else if (pop_acc && !push_acc && (fifo_count == CW'(1))) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (pop_acc) begin
                        state_d = ST_PARTIAL;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // Sticky overflow flag; only reset clears it.
    always_comb begin
        overflow_d = overflow_q | push_drop;
    end

    // FSM and overflow registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_EMPTY;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            overflow_q <= overflow_d;
        end
    end

    assign overflow_err = overflow_q;

`ifdef SPINE_OBUF_STATS_EN
    logic [15:0] fwd_cnt_q, fwd_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // Saturating forward/drop counters; flush leaves them untouched.
    always_comb begin
        fwd_cnt_d  = fwd_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (pop_acc && (fwd_cnt_q != 16'hFFFF)) begin
            fwd_cnt_d = fwd_cnt_q + 16'd1;
        end
        if (push_drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    // Statistics registers, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fwd_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            fwd_cnt_q  <= fwd_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign pkt_fwd_cnt  = fwd_cnt_q;
    assign pkt_drop_cnt = drop_cnt_q;
`else
    // No statistics counters in this build.
`endif

endmodule

// File: tb/tb_spine_out_port_buffer.sv
// Testbench for spine_out_port_buffer. Stimulus pushes expected packets
// into a queue; a negedge monitor pops and compares on every handshake.
module tb_spine_out_port_buffer;

    localparam int DW    = 16;
    localparam int DEPTH = 4;

    logic          clk;
    logic          reset;
    logic [DW-1:0] wr_data;
    logic          wr_valid;
    logic          fifo_full;
    logic          flush;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          overflow_err;
`ifdef SPINE_OBUF_STATS_EN
    logic [15:0]   pkt_fwd_cnt;
    logic [15:0]   pkt_drop_cnt;
`endif

    spine_out_port_buffer #(
        .DWIDTH (DW),
        .DEPTH  (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_data      (wr_data),
        .wr_valid     (wr_valid),
        .fifo_full    (fifo_full),
        .flush        (flush),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .overflow_err (overflow_err)
`ifdef SPINE_OBUF_STATS_EN
        ,
        .pkt_fwd_cnt  (pkt_fwd_cnt),
        .pkt_drop_cnt (pkt_drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            total = 0;
    int            bad   = 0;
    logic [DW-1:0] exp_q[$];
    int            mdl_cnt = 0;
    logic          mdl_ovf = 1'b0;
    int            mdl_fwd = 0;
    int            mdl_drop = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: check outputs left by the previous edge, then drive inputs
    // for the next edge and advance the reference model.
    task automatic cycle(input logic rst_n, input logic wv, input logic [DW-1:0] wd,
                         input logic rdy, input logic fl);
        logic do_pop;
        @(posedge clk);
        #1;
        chk("out_valid", {31'd0, out_valid}, {31'd0, mdl_cnt != 0});
        chk("fifo_full", {31'd0, fifo_full}, {31'd0, mdl_cnt == DEPTH});
        chk("overflow_err", {31'd0, overflow_err}, {31'd0, mdl_ovf});
`ifdef SPINE_OBUF_STATS_EN
        chk("pkt_fwd_cnt", {16'd0, pkt_fwd_cnt}, mdl_fwd);
        chk("pkt_drop_cnt", {16'd0, pkt_drop_cnt}, mdl_drop);
`endif
        reset     = rst_n;
        wr_valid  = wv;
        wr_data   = wd;
        out_ready = rdy;
        flush     = fl;
        $display("cycle t=%0t rst_n=%0b wv=%0b wd=%h rdy=%0b fl=%0b cnt=%0d",
                 $time, rst_n, wv, wd, rdy, fl, mdl_cnt);
        if (!rst_n) begin
            mdl_cnt  = 0;
            mdl_ovf  = 1'b0;
            mdl_fwd  = 0;
            mdl_drop = 0;
            exp_q.delete();
        end else if (fl) begin
            mdl_cnt = 0;
            exp_q.delete();
        end else begin
            do_pop = (mdl_cnt != 0) && rdy;
            if (wv && mdl_cnt == DEPTH) begin
                mdl_ovf = 1'b1;
                if (mdl_drop < 16'hFFFF) mdl_drop++;
            end else if (wv) begin
                exp_q.push_back(wd);
                mdl_cnt++;
            end
            if (do_pop) begin
                mdl_cnt--;
                if (mdl_fwd < 16'hFFFF) mdl_fwd++;
            end
        end
    endtask

    // Monitor: compare the head packet on every accepted pop, and check that a
    // stalled head stays put.
    logic          hold_prev = 1'b0;
    logic [DW-1:0] hold_data;
    always @(negedge clk) begin
        if (hold_prev && reset && !flush) begin
            chk("hold_data", {16'd0, out_data}, {16'd0, hold_data});
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
        end
        hold_prev = reset && !flush && (out_valid === 1'b1) && !out_ready;
        hold_data = out_data;
        if (reset && !flush && (out_valid === 1'b1) && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL pop_unexpected: got %h required no packet at %0t", out_data, $time);
            end else begin
                chk("pop_data", {16'd0, out_data}, {16'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        reset     = 1'b0;
        wr_valid  = 1'b0;
        wr_data   = '0;
        out_ready = 1'b0;
        flush     = 1'b0;

        // Reset held for two edges; first cycle call checks reset outputs.
        cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);

        // Single packet, one-cycle fall-through then pop.
        cycle(1'b1, 1'b1, 16'hA401, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);

        // Fill to full, overflow a fifth push, then drain.
        for (int i = 1; i <= 5; i++) begin
            cycle(1'b1, 1'b1, 16'(i), 1'b0, 1'b0);
        end
        cycle(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
        end

        // Count held at 2 with simultaneous push/pop; pointers wrap.
        cycle(1'b1, 1'b1, 16'h0010, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 16'h0011, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b1, 16'h0020 + 16'(i), 1'b1, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
        end

        // Full with push and pop together: pop wins, push dropped.
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b1, 16'h0030 + 16'(i), 1'b0, 1'b0);
        end
        cycle(1'b1, 1'b1, 16'h0099, 1'b1, 1'b0);
        // Now count=3: flush together with a push and pop.
        cycle(1'b1, 1'b1, 16'h0077, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 16'h0, 1'b1, 1'b0);

        // Reset mid-transfer at count=2, then a fresh push.
        cycle(1'b1, 1'b1, 16'h1111, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 16'h2222, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 16'hBEEF, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);

        chk("all_drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
